regfile_writeback_arbiter: RTL and testbench
============================================

// Module: regfile_writeback_arbiter
// PURPOSE
//  Sole writer of the register_file write port (WriteEnable/WriteAddress/WriteData).
//  Merges two result sources: the in-order ALU writeback (no backpressure) and the
//  multi-cycle mult/div unit (valid/ready), buffered in a DEPTH-entry FIFO.
//  Exposes a lookup port so decode can forward values still queued for writeback.
// PARAMETERS
//  N      32  data width; register count is also N (address width $clog2(N))
//  DEPTH  4   mult/div FIFO entries (power of 2, >= 2)
// PORTS
//  CLK            in   1           clock, all state on rising edge
//  RST_N          in   1           asynchronous, active-low reset
//  AluValid       in   1           ALU result present this cycle
//  AluAddress     in   $clog2(N)   ALU destination register
//  AluData        in   N           ALU result
//  MduValid       in   1           mult/div result offered
//  MduReady       out  1           FIFO can accept; equals !full
//  MduAddress     in   $clog2(N)   mult/div destination register
//  MduData        in   N           mult/div result
//  LookupAddress  in   $clog2(N)   forwarding query address
//  LookupHit      out  1           valid queued entry matches LookupAddress
//  LookupData     out  N           data of youngest matching entry (0 if no hit)
//  Count          out  $clog2(DEPTH)+1  occupied FIFO slots, killed slots included
//  WriteEnable    out  1           to register_file
//  WriteAddress   out  $clog2(N)   to register_file
//  WriteData      out  N           to register_file
// BEHAVIOUR
//  - Reset (RST_N low, async): FIFO empty, all entry valid bits 0, WriteEnable=0,
//    WriteAddress=0, WriteData=0, Count=0, MduReady=1, LookupHit=0.
//  - Write outputs are registered: source selected in cycle t appears at t+1.
//  - Priority per cycle: AluValid wins the port; otherwise FIFO head is popped.
//  - Popped head with valid=1 -> WriteEnable=1 with its address/data; popped
//    killed head (valid=0) -> slot freed, WriteEnable=0 that cycle.
//  - Address 0 ($zero): ALU write with address 0 gives WriteEnable=0; mult/div
//    push to address 0 completes handshake but is not stored.
//  - Push: MduValid && MduReady. MduReady depends only on full, so when full a
//    same-cycle pop does NOT allow a push (no combinational path ready<-pop).
//  - Push and pop in same cycle: Count unchanged; FIFO pointers wrap mod DEPTH.
//  - Kill rule: AluValid with address A!=0 clears valid on every entry already
//    in FIFO with address A (older result must not overwrite newer). An entry
//    pushed in the same cycle is younger and is NOT killed.
//  - Lookup: combinational over valid entries; youngest match wins; address 0
//    never hits. Killed entries never hit. Registered output stage not searched.
//  - Empty and AluValid=0: WriteEnable=0, WriteAddress/WriteData hold last value.
//  - Count counts slots, so a killed entry still occupies space until popped.
// TESTING
//  1 Reset mid-drain: 3 entries queued, RST_N low -> next edge-free check
//    WriteEnable=0, Count=0, MduReady=1 immediately.
//  2 ALU only: AluValid, addr 5, data 0xDEADBEEF -> next cycle WE=1, WA=5,
//    WD=0xDEADBEEF; addr 0 -> WE=0.
//  3 Priority: push mdu(7,0x11), ALU(3,0x22) 4 cycles -> WE stream 3,3,3,3,
//    then 7/0x11 on cycle after ALU stops; Count 1 then 0.
//  4 Full: push 4 entries with ALU busy -> MduReady=0, Count=4; 5th offer
//    held until a pop, then accepted; order of writes preserved.
//  5 Kill: queue mdu(9,0xAA), then ALU(9,0xBB) -> WD=0xBB at addr 9, popped
//    killed slot gives WE=0; LookupAddress=9 hit goes 1->0 after ALU cycle.
//  6 Lookup youngest: queue (4,0x1),(4,0x2) -> LookupHit=1, LookupData=0x2.

Source files
------------

// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter: sole writer of the register file write port.
// Merges ALU writeback with a FIFO-buffered mult/div result stream.
//
// Purpose
//   The ALU result always owns the write port in the cycle it arrives.
//   Mult/div results wait in a DEPTH-entry FIFO and drain when the ALU
//   is idle. A newer ALU write to a register kills any older queued
//   result for that register, so stale data never overwrites it.
//   Decode can search the queue through the lookup port to forward
//   values that have not reached the register file yet.
//
// Ports
//   CLK, RST_N         clock, async active-low reset
//   AluValid/Address/Data   ALU result, no backpressure
//   MduValid/Ready/Address/Data  mult/div result, valid/ready
//   LookupAddress/Hit/Data  forwarding query over queued entries
//   Count              occupied FIFO slots (killed slots included)
//   WriteEnable/Address/Data  registered register-file write port
module regfile_writeback_arbiter #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       AluValid,
  input  logic [$clog2(N)-1:0]       AluAddress,
  input  logic [N-1:0]               AluData,
  input  logic                       MduValid,
  output logic                       MduReady,
  input  logic [$clog2(N)-1:0]       MduAddress,
  input  logic [N-1:0]               MduData,
  input  logic [$clog2(N)-1:0]       LookupAddress,
  output logic                       LookupHit,
  output logic [N-1:0]               LookupData,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       WriteEnable,
  output logic [$clog2(N)-1:0]       WriteAddress,
  output logic [N-1:0]               WriteData
);

  localparam int AW = $clog2(N);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage
  logic [AW-1:0]    r_addr [DEPTH];
  logic [N-1:0]     r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [CW-1:0]    r_count;

  // Registered write port
  logic             r_we;
  logic [AW-1:0]    r_wa;
  logic [N-1:0]     r_wd;

  // Handshake / control
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_store;
  logic             w_pop;
  logic             w_kill;
  logic             w_head_vld;
  logic [DEPTH-1:0] w_kill_vec;
  logic [DEPTH-1:0] w_vld_nxt;

  // Lookup
  logic             w_hit;
  logic [N-1:0]     w_ldata;
  logic [PW-1:0]    w_lk_idx;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Ready depends only on occupancy, never on this cycle's pop.
  assign w_push  = MduValid && !w_full;
  // A push to $zero completes the handshake but occupies no slot.
  assign w_store = w_push && (MduAddress != '0);
  assign w_pop   = !AluValid && !w_empty;
  assign w_kill  = AluValid && (AluAddress != '0);

  assign w_head_vld = r_vld[r_rd];

  // Entries already queued for the ALU's target are superseded.
  always_comb begin
    w_kill_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_kill_vec[i] = w_kill && r_vld[i]
                    && (r_addr[i] == AluAddress);
    end
  end

  // Kill first, then free the popped slot, then mark the new slot.
  // The same-cycle push lands last, so it is never killed.
  always_comb begin
    w_vld_nxt = r_vld & ~w_kill_vec;
    if (w_pop) begin
      w_vld_nxt[r_rd] = 1'b0;
    end
    if (w_store) begin
      w_vld_nxt[r_wr] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_vld   <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      r_vld <= w_vld_nxt;
      if (w_pop) begin
        r_rd <= r_rd + PW'(1);
      end
      if (w_store) begin
        r_wr <= r_wr + PW'(1);
      end
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset; valid bits guard every use.
  always_ff @(posedge CLK) begin
    if (w_store) begin
      r_addr[r_wr] <= MduAddress;
      r_data[r_wr] <= MduData;
    end
  end

  // Address/data only move when a real write happens, otherwise
  // they hold the last written value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_we <= 1'b0;
      r_wa <= '0;
      r_wd <= '0;
    end else begin
      unique case (1'b1)
        AluValid: begin
          r_we <= w_kill;
          if (w_kill) begin
            r_wa <= AluAddress;
            r_wd <= AluData;
          end
        end
        w_pop: begin
          r_we <= w_head_vld;
          if (w_head_vld) begin
            r_wa <= r_addr[r_rd];
            r_wd <= r_data[r_rd];
          end
        end
        default: begin
          r_we <= 1'b0;
        end
      endcase
    end
  end

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    w_hit    = 1'b0;
    w_ldata  = '0;
    w_lk_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_lk_idx = r_rd + PW'(i);
      if (r_vld[w_lk_idx]
          && (r_addr[w_lk_idx] == LookupAddress)
          && (LookupAddress != '0)) begin
        w_hit   = 1'b1;
        w_ldata = r_data[w_lk_idx];
      end
    end
  end

  assign MduReady     = !w_full;
  assign LookupHit    = w_hit;
  assign LookupData   = w_ldata;
  assign Count        = r_count;
  assign WriteEnable  = r_we;
  assign WriteAddress = r_wa;
  assign WriteData    = r_wd;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb_regfile_writeback_arbiter: directed + random checks of the
// writeback arbiter against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_regfile_writeback_arbiter;

  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic        CLK;
  logic        RST_N;
  logic        AluValid;
  logic [4:0]  AluAddress;
  logic [31:0] AluData;
  logic        MduValid;
  logic        MduReady;
  logic [4:0]  MduAddress;
  logic [31:0] MduData;
  logic [4:0]  LookupAddress;
  logic        LookupHit;
  logic [31:0] LookupData;
  logic [2:0]  Count;
  logic        WriteEnable;
  logic [4:0]  WriteAddress;
  logic [31:0] WriteData;

  regfile_writeback_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .AluValid(AluValid),
    .AluAddress(AluAddress),
    .AluData(AluData),
    .MduValid(MduValid),
    .MduReady(MduReady),
    .MduAddress(MduAddress),
    .MduData(MduData),
    .LookupAddress(LookupAddress),
    .LookupHit(LookupHit),
    .LookupData(LookupData),
    .Count(Count),
    .WriteEnable(WriteEnable),
    .WriteAddress(WriteAddress),
    .WriteData(WriteData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Behavioural model: a queue of pending results, oldest first.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          v;
  } ent_t;

  ent_t        mq[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;

  task automatic model_reset();
    mq.delete();
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  task automatic model_step();
    ent_t e;
    bit   can_push;
    can_push = MduValid && (mq.size() < DEPTH);
    if (AluValid) begin
      m_we = (AluAddress != 0);
      if (AluAddress != 0) begin
        foreach (mq[i])
          if (mq[i].a == AluAddress) mq[i].v = 1'b0;
        m_wa = AluAddress;
        m_wd = AluData;
      end
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = e.v;
      if (e.v) begin
        m_wa = e.a;
        m_wd = e.d;
      end
    end else begin
      m_we = 1'b0;
    end
    if (can_push && MduAddress != 0) begin
      e.a = MduAddress;
      e.d = MduData;
      e.v = 1'b1;
      mq.push_back(e);
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) model_reset();
      else model_step();
    end
  end

  // Compare every cycle, well away from the rising edge.
  initial begin
    bit          eh;
    logic [31:0] ed;
    forever begin
      @(negedge CLK);
      #2;
      eh = 1'b0;
      ed = '0;
      if (LookupAddress != 0)
        foreach (mq[i])
          if (mq[i].v && mq[i].a == LookupAddress) begin
            eh = 1'b1;
            ed = mq[i].d;
          end
      chk("cyc_ready", 64'(MduReady), 64'(mq.size() < DEPTH));
      chk("cyc_count", 64'(Count), 64'(mq.size()));
      chk("cyc_hit", 64'(LookupHit), 64'(eh));
      chk("cyc_ldata", 64'(LookupData), 64'(ed));
      chk("cyc_we", 64'(WriteEnable), 64'(m_we));
      chk("cyc_wa", 64'(WriteAddress), 64'(m_wa));
      chk("cyc_wd", 64'(WriteData), 64'(m_wd));
    end
  end

  task automatic drive(input logic av, input logic [4:0] aa,
                       input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma,
                       input logic [31:0] md,
                       input logic [4:0] la);
    AluValid      = av;
    AluAddress    = aa;
    AluData       = ad;
    MduValid      = mv;
    MduAddress    = ma;
    MduData       = md;
    LookupAddress = la;
    @(negedge CLK);
    #1;
  endtask

  task automatic idle(input logic [4:0] la);
    drive(0, 0, 0, 0, 0, 0, la);
  endtask

  initial begin
    int pct;
    RST_N = 1'b0;
    AluValid = 0; AluAddress = 0; AluData = 0;
    MduValid = 0; MduAddress = 0; MduData = 0;
    LookupAddress = 0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_we", 64'(WriteEnable), 64'd0);
    chk("rst_wa", 64'(WriteAddress), 64'd0);
    chk("rst_wd", 64'(WriteData), 64'd0);
    chk("rst_cnt", 64'(Count), 64'd0);
    chk("rst_rdy", 64'(MduReady), 64'd1);
    chk("rst_hit", 64'(LookupHit), 64'd0);
    RST_N = 1'b1;

    // ALU only
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    chk("alu_we", 64'(WriteEnable), 64'd1);
    chk("alu_wa", 64'(WriteAddress), 64'd5);
    chk("alu_wd", 64'(WriteData), 64'hDEADBEEF);
    drive(1, 0, 32'h12345678, 0, 0, 0, 0);
    chk("alu_zero_we", 64'(WriteEnable), 64'd0);
    chk("alu_zero_wa", 64'(WriteAddress), 64'd5);

    // Priority
    drive(1, 3, 32'h22, 1, 7, 32'h11, 0);
    chk("pri_cnt1", 64'(Count), 64'd1);
    chk("pri_wa0", 64'(WriteAddress), 64'd3);
    for (int k = 0; k < 3; k++) begin
      drive(1, 3, 32'h22, 0, 0, 0, 0);
      chk("pri_wa_alu", 64'(WriteAddress), 64'd3);
      chk("pri_cnt", 64'(Count), 64'd1);
    end
    idle(0);
    chk("pri_we_mdu", 64'(WriteEnable), 64'd1);
    chk("pri_wa_mdu", 64'(WriteAddress), 64'd7);
    chk("pri_wd_mdu", 64'(WriteData), 64'h11);
    chk("pri_cnt0", 64'(Count), 64'd0);

    // Full
    for (int k = 0; k < 4; k++)
      drive(1, 1, 32'h5, 1, 5'(10 + k), 32'(100 + k), 0);
    chk("full_cnt", 64'(Count), 64'd4);
    chk("full_rdy", 64'(MduReady), 64'd0);
    drive(1, 1, 32'h5, 1, 14, 32'd104, 0);
    chk("full_hold", 64'(Count), 64'd4);
    drive(0, 0, 0, 1, 14, 32'd104, 0);
    chk("full_pop_wa", 64'(WriteAddress), 64'd10);
    chk("full_pop_cnt", 64'(Count), 64'd3);
    drive(0, 0, 0, 1, 14, 32'd104, 0);
    chk("full_pp_wa", 64'(WriteAddress), 64'd11);
    chk("full_pp_cnt", 64'(Count), 64'd3);
    for (int k = 0; k < 3; k++) begin
      idle(0);
      chk("full_drain_wa", 64'(WriteAddress), 64'(12 + k));
      chk("full_drain_wd", 64'(WriteData), 64'(102 + k));
    end
    chk("full_empty", 64'(Count), 64'd0);

    // Kill
    drive(1, 1, 32'h5, 1, 9, 32'hAA, 9);
    chk("kill_hit1", 64'(LookupHit), 64'd1);
    chk("kill_ld1", 64'(LookupData), 64'hAA);
    drive(1, 9, 32'hBB, 0, 0, 0, 9);
    chk("kill_wa", 64'(WriteAddress), 64'd9);
    chk("kill_wd", 64'(WriteData), 64'hBB);
    chk("kill_hit0", 64'(LookupHit), 64'd0);
    chk("kill_cnt", 64'(Count), 64'd1);
    idle(9);
    chk("kill_pop_we", 64'(WriteEnable), 64'd0);
    chk("kill_pop_cnt", 64'(Count), 64'd0);

    // Lookup youngest
    drive(1, 1, 32'h5, 1, 4, 32'h1, 4);
    drive(1, 1, 32'h5, 1, 4, 32'h2, 4);
    chk("young_hit", 64'(LookupHit), 64'd1);
    chk("young_ld", 64'(LookupData), 64'h2);
    idle(0);
    idle(0);

    // Reset mid-drain
    for (int k = 0; k < 3; k++)
      drive(1, 1, 32'h5, 1, 5'(20 + k), 32'(200 + k), 21);
    chk("rmd_cnt3", 64'(Count), 64'd3);
    AluValid = 0;
    MduValid = 0;
    RST_N = 1'b0;
    #1;
    chk("rmd_we", 64'(WriteEnable), 64'd0);
    chk("rmd_cnt", 64'(Count), 64'd0);
    chk("rmd_rdy", 64'(MduReady), 64'd1);
    chk("rmd_hit", 64'(LookupHit), 64'd0);
    @(negedge CLK);
    #1;
    RST_N = 1'b1;

    // Random traffic, alternating ALU-heavy and ALU-light phases
    for (int k = 0; k < 3000; k++) begin
      pct = ((k / 300) % 2 == 0) ? 75 : 25;
      drive(($urandom_range(0, 99) < pct),
            5'($urandom_range(0, 7)), $urandom(),
            ($urandom_range(0, 99) < 60),
            5'($urandom_range(0, 7)), $urandom(),
            5'($urandom_range(0, 7)));
    end
    repeat (8) idle(0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
